// File: rtl/router_pkg.sv
// Shared router constants: data width, the unroutable address code and where
// the payload length sits inside the header byte.
package router_pkg;

    localparam int DATA_W = 8;
    localparam logic [1:0] ADDR_INVALID = 2'b11;
    localparam int LEN_LSB = 2;
    localparam int LEN_W = 6;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    function automatic logic addr_ok(input logic [1:0] addr);
        return addr != ADDR_INVALID;
    endfunction

endpackage

// File: rtl/router_reg.sv
// Router datapath register: forwards header/payload/parity bytes to the FIFO,
// covers FIFO-full stalls with a hold byte and checks parity and length inline.
module router_reg #(
    parameter int DATA_W = router_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              lfd_state,
    input  logic              rst_int_reg,
    output logic [DATA_W-1:0] dout,
    output logic              parity_done,
    output logic              low_pkt_valid,
    output logic              err,
    output logic              len_err
);
    import router_pkg::*;

    logic [DATA_W-1:0] header_byte_reg;
    logic [DATA_W-1:0] hold_byte_reg;
    logic [DATA_W-1:0] internal_parity_reg;
    logic [DATA_W-1:0] packet_parity_reg;
    logic [LEN_W-1:0]  payload_cnt_reg;
    logic              parity_done_d_reg;

    logic new_pkt;
    logic load_byte;
    logic stall_byte;
    logic count_byte;
    logic parity_byte;
    logic pd_set;
    logic pd_rise;

    assign new_pkt     = detect_add && pkt_valid && addr_ok(data_in[1:0]);
    assign load_byte   = ld_state && !fifo_full;
    assign stall_byte  = ld_state && fifo_full;
    // full_state (not fifo_full) gates counting: the byte seen while ld_state
    // meets a full FIFO is parked in hold_byte but still belongs to the packet.
    assign count_byte  = pkt_valid && ld_state && !full_state;
    assign parity_byte = ld_state && !pkt_valid;
    assign pd_set      = (load_byte && !pkt_valid) ||
                         (laf_state && low_pkt_valid && !parity_done);
    assign pd_rise     = parity_done && !parity_done_d_reg;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dout            <= '0;
            header_byte_reg <= '0;
            hold_byte_reg   <= '0;
        end else begin
            if (new_pkt)
                header_byte_reg <= data_in;
            if (stall_byte)
                hold_byte_reg <= data_in;
            if (lfd_state)
                dout <= header_byte_reg;
            else if (load_byte)
                dout <= data_in;
            else if (laf_state)
                dout <= hold_byte_reg;
        end
    end

    // A new header also covers an FSM abort: partial parity and count are dropped.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            internal_parity_reg <= '0;
            packet_parity_reg   <= '0;
            payload_cnt_reg     <= '0;
        end else begin
            if (new_pkt) begin
                internal_parity_reg <= '0;
                payload_cnt_reg     <= '0;
            end else if (lfd_state) begin
                internal_parity_reg <= internal_parity_reg ^ header_byte_reg;
            end else if (count_byte) begin
                internal_parity_reg <= internal_parity_reg ^ data_in;
                if (payload_cnt_reg != LEN_MAX)
                    payload_cnt_reg <= payload_cnt_reg + LEN_W'(1);
            end
            if (parity_byte)
                packet_parity_reg <= data_in;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            low_pkt_valid     <= 1'b0;
            parity_done       <= 1'b0;
            parity_done_d_reg <= 1'b0;
            err               <= 1'b0;
            len_err           <= 1'b0;
        end else begin
            if (parity_byte)
                low_pkt_valid <= 1'b1;
            else if (rst_int_reg)
                low_pkt_valid <= 1'b0;

            if (pd_set)
                parity_done <= 1'b1;
            else if (detect_add)
                parity_done <= 1'b0;
            parity_done_d_reg <= parity_done;

            // Verdicts are taken the cycle after parity_done rises, once the
            // parity byte and final count have settled.
            if (detect_add) begin
                err     <= 1'b0;
                len_err <= 1'b0;
            end else if (pd_rise) begin
                err     <= internal_parity_reg != packet_parity_reg;
                len_err <= payload_cnt_reg != header_byte_reg[LEN_LSB +: LEN_W];
            end
        end
    end

endmodule

// File: tb/tb_router_reg.sv
// Drives router_fsm-style strobe sequences into router_reg and checks every
// forwarded byte and the packet verdicts against a packet-level model.
module tb_router_reg;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid, fifo_full;
    logic       detect_add, ld_state, laf_state, full_state, lfd_state, rst_int_reg;
    logic [7:0] data_in, dout;
    logic       parity_done, low_pkt_valid, err, len_err;

    int checks = 0;
    int failures = 0;
    int pd_rises = 0;

    logic [7:0] pl [0:79];
    bit         stall [0:79];
    int         pl_n;
    bit         par_stall;
    int         abort_at;

    always #5 clock = ~clock;
    always @(posedge parity_done) pd_rises++;

    router_reg #(.DATA_W(8)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .detect_add(detect_add), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .lfd_state(lfd_state),
        .rst_int_reg(rst_int_reg), .dout(dout), .parity_done(parity_done),
        .low_pkt_valid(low_pkt_valid), .err(err), .len_err(len_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        detect_add = 0; ld_state = 0; laf_state = 0; full_state = 0;
        lfd_state = 0; rst_int_reg = 0; fifo_full = 0; pkt_valid = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Sends header hdr, payload pl[0..pl_n-1] and parity byte par.
    task automatic send_packet(input logic [7:0] hdr, input logic [7:0] par, input string name);
        logic [7:0] xsum;
        logic [7:0] last_exp;
        int         cnt;
        int         rises0;
        bit         e_err, e_len;
        xsum = hdr;
        for (int i = 0; i < pl_n; i++) xsum = xsum ^ pl[i];
        cnt    = (pl_n > 63) ? 63 : pl_n;
        e_err  = (par != xsum);
        e_len  = (cnt != int'(hdr[7:2]));

        idle(); detect_add = 1; pkt_valid = 1; data_in = hdr;
        step();
        check("new_pd_clr", parity_done, 0);
        check("new_err_clr", err, 0);
        check("new_len_clr", len_err, 0);

        idle(); lfd_state = 1; pkt_valid = 1; data_in = (pl_n > 0) ? pl[0] : par;
        step();
        check("dout_hdr", dout, hdr);
        last_exp = hdr;

        for (int i = 0; i < pl_n; i++) begin
            if (i == abort_at) begin
                idle();
                $display("pkt %s hdr=%02h aborted after %0d bytes", name, hdr, i);
                return;
            end
            idle(); ld_state = 1; pkt_valid = 1; data_in = pl[i];
            if (stall[i]) begin
                fifo_full = 1;
                step();
                check("dout_hold", dout, last_exp);
                for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                    idle(); full_state = 1; fifo_full = 1; pkt_valid = 1;
                    step();
                end
                idle(); laf_state = 1; pkt_valid = 1;
                step();
                check("dout_laf", dout, pl[i]);
            end else begin
                step();
                check("dout_pay", dout, pl[i]);
            end
            last_exp = pl[i];
        end

        rises0 = pd_rises;
        idle(); ld_state = 1; pkt_valid = 0; data_in = par;
        if (par_stall) begin
            fifo_full = 1;
            step();
            check("lpv_stall", low_pkt_valid, 1);
            check("pd_not_yet", parity_done, 0);
            idle(); laf_state = 1;
            step();
            check("dout_par_laf", dout, par);
        end else begin
            step();
            check("dout_par", dout, par);
        end
        check("lpv_set", low_pkt_valid, 1);
        check("pd_set", parity_done, 1);
        check("err_wait", err, 0);
        check("len_wait", len_err, 0);

        idle(); rst_int_reg = 1;
        step();
        check("err", err, e_err);
        check("len_err", len_err, e_len);
        check("lpv_clr", low_pkt_valid, 0);
        check("pd_hold", parity_done, 1);
        check("pd_once", pd_rises - rises0, 1);

        idle();
        step();
        check("err_hold", err, e_err);
        $display("pkt %s hdr=%02h n=%0d par=%02h err=%0d len_err=%0d", name, hdr, pl_n, par,
                 err, len_err);
    endtask

    function automatic logic [7:0] good_par(input logic [7:0] hdr);
        logic [7:0] x;
        x = hdr;
        for (int i = 0; i < pl_n; i++) x = x ^ pl[i];
        return x;
    endfunction

    task automatic clear_opts();
        for (int i = 0; i < 80; i++) stall[i] = 0;
        par_stall = 0;
        abort_at = -1;
    endtask

    initial begin
        logic [7:0] hdr, par;
        idle(); data_in = 0; resetn = 0;
        clear_opts();
        #1;
        check("rst_dout", dout, 0);
        check("rst_pd", parity_done, 0);
        check("rst_lpv", low_pkt_valid, 0);
        check("rst_err", err, 0);
        check("rst_len", len_err, 0);
        step(); step();
        resetn = 1;
        step();

        // Basic good packet.
        pl_n = 3; pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_packet(8'h0D, good_par(8'h0D), "good");
        // Bad parity, then cleared by next header.
        send_packet(8'h0D, 8'hFF, "badpar");
        // Length mismatch.
        pl_n = 3;
        send_packet(8'h10, good_par(8'h10), "badlen");
        // FIFO full on A5 then laf.
        pl_n = 3; pl[0] = 8'h5C; pl[1] = 8'hA5; pl[2] = 8'h3E; stall[1] = 1;
        send_packet(8'h0E, good_par(8'h0E), "stall");
        // Packet ends in laf with low_pkt_valid.
        clear_opts(); par_stall = 1;
        send_packet(8'h0E, good_par(8'h0E), "parstall");
        // Zero-length packet.
        clear_opts(); pl_n = 0;
        send_packet(8'h02, good_par(8'h02), "len0");
        // Saturating payload count.
        pl_n = 70;
        for (int i = 0; i < 70; i++) pl[i] = 8'($urandom);
        send_packet(8'hFC, good_par(8'hFC), "sat63");
        // Abort mid-packet, then a clean packet.
        pl_n = 4; abort_at = 2;
        for (int i = 0; i < 4; i++) pl[i] = 8'hC0 + 8'(i);
        send_packet(8'h11, 8'h00, "abort");
        abort_at = -1; pl_n = 2;
        send_packet(8'h09, good_par(8'h09), "after_abort");

        // Asynchronous reset mid-payload.
        idle(); detect_add = 1; pkt_valid = 1; data_in = 8'h0D; step();
        idle(); lfd_state = 1; pkt_valid = 1; step();
        idle(); ld_state = 1; pkt_valid = 1; data_in = 8'h77; step();
        #2 resetn = 0;
        #1;
        check("async_dout", dout, 0);
        check("async_pd", parity_done, 0);
        check("async_lpv", low_pkt_valid, 0);
        check("async_err", err, 0);
        check("async_len", len_err, 0);
        idle(); step();
        resetn = 1;
        step();
        pl_n = 3; pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_packet(8'h0D, good_par(8'h0D), "post_reset");

        // Randomized packets.
        for (int p = 0; p < 40; p++) begin
            clear_opts();
            pl_n = $urandom_range(0, 8);
            for (int i = 0; i < pl_n; i++) begin
                pl[i] = 8'($urandom);
                stall[i] = ($urandom_range(0, 3) == 0);
            end
            par_stall = ($urandom_range(0, 3) == 0);
            hdr[1:0] = 2'($urandom_range(0, 2));
            hdr[7:2] = ($urandom_range(0, 1) == 0) ? 6'(pl_n) : 6'($urandom_range(0, 63));
            par = good_par(hdr);
            if ($urandom_range(0, 2) == 0) par = par ^ 8'(1 << $urandom_range(0, 7));
            if (pl_n > 0 && $urandom_range(0, 7) == 0) abort_at = $urandom_range(0, pl_n - 1);
            send_packet(hdr, par, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
